// File: rtl/data_mem_pkg.sv
// Shared types and constants for the multi-cycle data memory.
// Holds the FSM state encoding, the latched operation codes and the default latency.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int ACCESS_CYCLES_DEFAULT = 5;
    localparam int CNT_W                 = 4;

    // Exactly one of READ/WRITE asserted; both high is an illegal request.
    function automatic logic valid_req(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// CPU-side load/store bus of the data memory: request levels, address/data and stall.
interface data_memory_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/dmem_array.sv
// Byte storage array: one synchronous write port, registered read port, clear on reset.
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage update; reset wins over a same-edge write so an aborted access never commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register only moves on a completed read, so writes leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_memory.sv
// Data memory with fixed multi-cycle latency; BUSYWAIT stalls the CPU until the access ends.
// Request fields are captured on acceptance so bus changes during BUSY have no effect.
module data_memory
    import data_mem_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT
) (
    input  logic         CLK,
    input  logic         RESET,
    data_memory_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic              req_s;
    logic              accept_s;
    logic              access_s;
    logic              busywait_s;
    logic              we_s;
    logic              re_s;

    assign req_s = valid_req(bus.read, bus.write);

    // Next-state and stall decode; IDLE stall is combinational so the first edge already stalls.
    always_comb begin
        next_state_s = state_r;
        busywait_s   = 1'b0;
        accept_s     = 1'b0;
        access_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    busywait_s   = 1'b1;
                    accept_s     = 1'b1;
                    next_state_s = BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                busywait_s = 1'b1;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    access_s     = 1'b1;
                    next_state_s = RESP;
                end else begin
                    next_state_s = BUSY;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, latency counter and captured request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= OP_READ;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                cnt_r   <= CNT_LOAD;
                op_r    <= bus.write ? OP_WRITE : OP_READ;
                addr_r  <= bus.address;
                wdata_r <= bus.writedata;
            end else if ((state_r == BUSY) && (cnt_r != {CNT_W{1'b0}})) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign we_s = access_s && (op_r == OP_WRITE);
    assign re_s = access_s && (op_r == OP_READ);

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (CLK),
        .reset (RESET),
        .we    (we_s),
        .re    (re_s),
        .addr  (addr_r),
        .wdata (wdata_r),
        .rdata (bus.readdata)
    );

    assign bus.busywait = busywait_s;

endmodule
